excp_redirect_ctrl: RTL and testbench
=====================================

Name: excp_redirect_ctrl

Overview:
- Controller that sequences every pipeline-wide redirect raised at writeback: exception entry, ertn return, and refetch after ibar/cacop/tlb-maintenance instructions.
- Arbitrates the three causes and waits for the icache to go idle.
- Emits the flush pulse(s) and one-cycle commit strobes to the CSR file, then holds the redirect PC towards IF until it is accepted.
- Sits between WB, the CSR unit and the IF/PC generator.

Parameters:
FLUSH_CYCLES, 1, number of consecutive cycles flush is asserted (1..15)
PC_W, 32, program-counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (reset==0 resets on rising clk edge)
wb_valid  in  1  WB holds a valid instruction this cycle
wb_excp  in  1  WB instruction carries an exception (includes interrupt)
wb_tlbrefill  in  1  exception is a TLB refill (qualifies wb_excp)
wb_ertn  in  1  WB instruction is ertn
wb_refetch  in  1  WB instruction requires refetch of pc+4
wb_pc  in  PC_W  PC of WB instruction
icache_busy  in  1  icache has an outstanding refill/cacop
csr_eentry  in  PC_W  CSR.EENTRY
csr_tlbrentry  in  PC_W  CSR.TLBRENTRY
csr_era  in  PC_W  CSR.ERA
wb_stall  out  1  hold WB (do not retire) this cycle
flush  out  1  kill all younger stages
excp_commit  out  1  one-cycle strobe: CSR records exception
ertn_commit  out  1  one-cycle strobe: CSR restores PLV/IE
commit_pc  out  PC_W  latched wb_pc, valid with excp_commit/ertn_commit
redirect_valid  out  1  redirect target valid to IF
redirect_pc  out  PC_W  redirect target
redirect_ready  in  1  IF accepts redirect

Behaviour:
- Reset: state IDLE. All outputs 0. Latched cause/target/pc = 0. Reset mid-operation aborts any flush or redirect in progress; no commit strobe is emitted that cycle.
- event = wb_valid & (wb_excp | wb_ertn | wb_refetch).
- Cause priority: wb_excp > wb_ertn > wb_refetch. Lower causes are ignored when a higher one is present.
- Target selection, latched on acceptance:
  - excp & tlbrefill -> csr_tlbrentry
  - excp -> csr_eentry
  - ertn -> csr_era
  - refetch -> wb_pc+4, modulo 2^PC_W, wraps silently.
- States: IDLE, WAIT_IC, FLUSH, REDIRECT.
- IDLE:
  - event & !icache_busy -> accept: latch cause, target, wb_pc; go to FLUSH.
  - event & icache_busy -> WAIT_IC; nothing latched.
  - wb_stall = event & icache_busy (combinational).
- WAIT_IC:
  - wb_stall = wb_valid.
  - Re-evaluates event every cycle. When icache_busy falls: accept with the values present that cycle, go to FLUSH.
  - If event drops (wb_valid=0), return to IDLE.
- FLUSH:
  - flush=1 for FLUSH_CYCLES cycles, counted by a 4-bit down-counter.
  - excp_commit or ertn_commit = 1 only in the first FLUSH cycle, with commit_pc = latched pc. Refetch emits no commit strobe.
  - wb_stall=0; WB contents are killed by the flush.
  - Counter reaches 0 -> REDIRECT.
- REDIRECT:
  - redirect_valid=1, redirect_pc=latched target, held stable until redirect_ready.
  - Transfer cycle (valid&ready) -> IDLE next cycle.
  - flush=0. Any event seen in this state is ignored; wb_stall = wb_valid.
- Latency, icache idle, FLUSH_CYCLES=1, IF ready:
  - accept at T, flush + commit at T+1, redirect_valid at T+2, IDLE at T+3.
  - A new event can be accepted at T+3.
- Simultaneous wb_excp & wb_ertn: treated as an exception. ertn_commit is never asserted.
- redirect_ready asserted outside REDIRECT: ignored.
- CSR inputs are sampled only at acceptance. Later changes do not affect redirect_pc.

Decomposition:
- Shared package `redirect_pkg`:
  - state enum {IDLE, WAIT_IC, FLUSH, REDIRECT}
  - cause enum {CAUSE_EXCP, CAUSE_TLBR, CAUSE_ERTN, CAUSE_REFETCH}
  - PC_W default constant
- Sub-module `redirect_target_sel`: combinational priority and target mux. Inputs are the cause bits and CSR values; outputs are the cause code and target. Reused by the bypass/diff logic.

Test Plan:
- wb_excp, pc=0x1c000100, eentry=0x1c008000, icache idle -> T+1 flush=1, excp_commit=1, commit_pc=0x1c000100; T+2 redirect_pc=0x1c008000, IDLE at T+3.
- wb_excp+wb_tlbrefill, tlbrentry=0x1c00f000, icache_busy high 5 cycles -> wb_stall=1 for 5 cycles, no flush; then flush and redirect_pc=0x1c00f000.
- wb_ertn, era=0x1c000204, redirect_ready low 3 cycles -> redirect_valid held 3+1 cycles with stable pc; ertn_commit pulses exactly once.
- wb_refetch, pc=0xfffffffc -> redirect_pc=0x00000000; no excp_commit/ertn_commit.
- FLUSH_CYCLES=3, wb_excp and wb_ertn both high -> flush high 3 consecutive cycles, only excp_commit, target=eentry.
- reset=0 asserted during REDIRECT -> next cycle all outputs 0, state IDLE; subsequent refetch is processed normally.

Source files
------------

// File: rtl/redirect_pkg.sv
// Shared types for the writeback redirect controller and its target selector.
// Combinational definitions only; no latency and no flow control of their own.
package redirect_pkg;

  localparam int PC_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_IC  = 2'd1,
    FLUSH    = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_EXCP    = 2'd0,
    CAUSE_TLBR    = 2'd1,
    CAUSE_ERTN    = 2'd2,
    CAUSE_REFETCH = 2'd3
  } cause_t;

endpackage

// File: rtl/redirect_target_sel.sv
// Priority encode of the writeback redirect causes (excp > ertn > refetch) plus target mux.
// Purely combinational, zero latency; it has no flow control and never stalls.
module redirect_target_sel
  import redirect_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic            excp,
  input  logic            tlbrefill,
  input  logic            ertn,
  input  logic            refetch,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] eentry,
  input  logic [PC_W-1:0] tlbrentry,
  input  logic [PC_W-1:0] era,
  output logic            hit,
  output logic [1:0]      cause,
  output logic [PC_W-1:0] target
);

  assign hit = excp | ertn | refetch;

  always_comb begin
    cause  = CAUSE_REFETCH;
    target = pc + PC_W'(4);
    if (excp) begin
      cause  = tlbrefill ? CAUSE_TLBR : CAUSE_EXCP;
      target = tlbrefill ? tlbrentry : eentry;
    end else if (ertn) begin
      cause  = CAUSE_ERTN;
      target = era;
    end
  end

endmodule

// File: rtl/excp_redirect_ctrl.sv
// Sequences WB redirects: accept -> FLUSH_CYCLES of flush (+commit strobe) -> hold redirect; accept-to-idle is FLUSH_CYCLES+2 cycles.
// Backpressure: stalls WB while the icache is busy, holds redirect_valid/pc until redirect_ready.
module excp_redirect_ctrl
  import redirect_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int PC_W         = PC_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_valid,
  input  logic            wb_excp,
  input  logic            wb_tlbrefill,
  input  logic            wb_ertn,
  input  logic            wb_refetch,
  input  logic [PC_W-1:0] wb_pc,
  input  logic            icache_busy,
  input  logic [PC_W-1:0] csr_eentry,
  input  logic [PC_W-1:0] csr_tlbrentry,
  input  logic [PC_W-1:0] csr_era,
  output logic            wb_stall,
  output logic            flush,
  output logic            excp_commit,
  output logic            ertn_commit,
  output logic [PC_W-1:0] commit_pc,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  input  logic            redirect_ready
);

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [1:0]      cause_q;
  logic [PC_W-1:0] target_q, pc_q;

  logic            sel_hit;
  logic [1:0]      sel_cause;
  logic [PC_W-1:0] sel_target;
  logic            evt, accept;
  logic            stall_c, flush_c, excp_c, ertn_c, rv_c;

  redirect_target_sel #(.PC_W(PC_W)) u_sel (
    .excp      (wb_excp),
    .tlbrefill (wb_tlbrefill),
    .ertn      (wb_ertn),
    .refetch   (wb_refetch),
    .pc        (wb_pc),
    .eentry    (csr_eentry),
    .tlbrentry (csr_tlbrentry),
    .era       (csr_era),
    .hit       (sel_hit),
    .cause     (sel_cause),
    .target    (sel_target)
  );

  assign evt = wb_valid & sel_hit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    stall_c = 1'b0;
    flush_c = 1'b0;
    excp_c  = 1'b0;
    ertn_c  = 1'b0;
    rv_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (evt) begin
          if (icache_busy) begin
            stall_c = 1'b1;
            state_d = WAIT_IC;
          end else begin
            accept  = 1'b1;
            cnt_d   = CNT_INIT;
            state_d = FLUSH;
          end
        end
      end
      WAIT_IC: begin
        stall_c = wb_valid;
        if (!evt) begin
          state_d = IDLE;
        end else if (!icache_busy) begin
          accept  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        flush_c = 1'b1;
        // Commit strobes fire once, on the first flush cycle only.
        if (cnt_q == CNT_INIT) begin
          excp_c = (cause_q == CAUSE_EXCP) || (cause_q == CAUSE_TLBR);
          ertn_c = (cause_q == CAUSE_ERTN);
        end
        if (cnt_q == 4'd0) begin
          state_d = REDIRECT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      REDIRECT: begin
        rv_c    = 1'b1;
        stall_c = wb_valid;
        if (redirect_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset masks every output in the cycle it is applied, so an aborted flush emits no strobe.
  assign wb_stall       = reset & stall_c;
  assign flush          = reset & flush_c;
  assign excp_commit    = reset & excp_c;
  assign ertn_commit    = reset & ertn_c;
  assign commit_pc      = (excp_commit | ertn_commit) ? pc_q : '0;
  assign redirect_valid = reset & rv_c;
  assign redirect_pc    = redirect_valid ? target_q : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      cause_q  <= 2'd0;
      target_q <= '0;
      pc_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        cause_q  <= sel_cause;
        target_q <= sel_target;
        pc_q     <= wb_pc;
      end
    end
  end

endmodule

// File: tb/tb_excp_redirect_ctrl.sv
// Directed bench for excp_redirect_ctrl: one instance with FLUSH_CYCLES=1 and one with 3, sharing stimulus.
module tb_excp_redirect_ctrl;
  import redirect_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_valid = 1'b0, wb_excp = 1'b0, wb_tlbrefill = 1'b0, wb_ertn = 1'b0, wb_refetch = 1'b0;
  logic [31:0] wb_pc = '0, csr_eentry = '0, csr_tlbrentry = '0, csr_era = '0;
  logic        icache_busy = 1'b0, redirect_ready = 1'b1;

  logic        d1_stall, d1_flush, d1_ec, d1_erc, d1_rv;
  logic [31:0] d1_cpc, d1_rpc;
  logic        d3_stall, d3_flush, d3_ec, d3_erc, d3_rv;
  logic [31:0] d3_cpc, d3_rpc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  excp_redirect_ctrl #(.FLUSH_CYCLES(1), .PC_W(32)) u_dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_excp(wb_excp), .wb_tlbrefill(wb_tlbrefill),
    .wb_ertn(wb_ertn), .wb_refetch(wb_refetch), .wb_pc(wb_pc), .icache_busy(icache_busy),
    .csr_eentry(csr_eentry), .csr_tlbrentry(csr_tlbrentry), .csr_era(csr_era),
    .wb_stall(d1_stall), .flush(d1_flush), .excp_commit(d1_ec), .ertn_commit(d1_erc),
    .commit_pc(d1_cpc), .redirect_valid(d1_rv), .redirect_pc(d1_rpc), .redirect_ready(redirect_ready)
  );

  excp_redirect_ctrl #(.FLUSH_CYCLES(3), .PC_W(32)) u_dut3 (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_excp(wb_excp), .wb_tlbrefill(wb_tlbrefill),
    .wb_ertn(wb_ertn), .wb_refetch(wb_refetch), .wb_pc(wb_pc), .icache_busy(icache_busy),
    .csr_eentry(csr_eentry), .csr_tlbrentry(csr_tlbrentry), .csr_era(csr_era),
    .wb_stall(d3_stall), .flush(d3_flush), .excp_commit(d3_ec), .ertn_commit(d3_erc),
    .commit_pc(d3_cpc), .redirect_valid(d3_rv), .redirect_pc(d3_rpc), .redirect_ready(redirect_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_wb();
    wb_valid = 1'b0; wb_excp = 1'b0; wb_tlbrefill = 1'b0; wb_ertn = 1'b0; wb_refetch = 1'b0;
  endtask

  task automatic settle(input int n);
    clear_wb();
    icache_busy = 1'b0;
    redirect_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    wb_valid = 1'b1; wb_excp = 1'b1; icache_busy = 1'b1;
    tick(); tick();
    #1;
    n_tests++; if ({d1_stall, d1_flush, d1_ec, d1_erc, d1_rv} !== 5'b0) begin n_fail++; $display("FAIL reset_flags1: got %b want 00000", {d1_stall, d1_flush, d1_ec, d1_erc, d1_rv}); end
    n_tests++; if ({d3_stall, d3_flush, d3_ec, d3_erc, d3_rv} !== 5'b0) begin n_fail++; $display("FAIL reset_flags3: got %b want 00000", {d3_stall, d3_flush, d3_ec, d3_erc, d3_rv}); end
    n_tests++; if (d1_cpc !== 32'h0 || d1_rpc !== 32'h0) begin n_fail++; $display("FAIL reset_pcs: commit_pc %h redirect_pc %h want 0", d1_cpc, d1_rpc); end
    n_tests++; if (u_dut.state_q !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", u_dut.state_q); end
    clear_wb(); icache_busy = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_excp_basic();
    wb_valid = 1'b1; wb_excp = 1'b1; wb_pc = 32'h1c000100;
    csr_eentry = 32'h1c008000; csr_tlbrentry = 32'h1c00f000; csr_era = 32'h1c000204;
    #1;
    n_tests++; if (d1_stall !== 1'b0) begin n_fail++; $display("FAIL excp_nostall: got %b want 0", d1_stall); end
    tick();
    clear_wb(); csr_eentry = 32'h11111110;
    #1;
    n_tests++; if (d1_flush !== 1'b1 || d1_ec !== 1'b1 || d1_erc !== 1'b0) begin n_fail++; $display("FAIL excp_t1: flush %b excp %b ertn %b want 1 1 0", d1_flush, d1_ec, d1_erc); end
    n_tests++; if (d1_cpc !== 32'h1c000100) begin n_fail++; $display("FAIL excp_commit_pc: got %h want 1c000100", d1_cpc); end
    n_tests++; if (d1_rv !== 1'b0) begin n_fail++; $display("FAIL excp_t1_rv: got %b want 0", d1_rv); end
    tick();
    n_tests++; if (d1_rv !== 1'b1 || d1_rpc !== 32'h1c008000) begin n_fail++; $display("FAIL excp_t2: valid %b pc %h want 1 1c008000", d1_rv, d1_rpc); end
    n_tests++; if (d1_flush !== 1'b0 || d1_ec !== 1'b0) begin n_fail++; $display("FAIL excp_t2_flush: flush %b excp %b want 0 0", d1_flush, d1_ec); end
    tick();
    n_tests++; if (u_dut.state_q !== IDLE || d1_rv !== 1'b0) begin n_fail++; $display("FAIL excp_t3_idle: state %0d valid %b want IDLE 0", u_dut.state_q, d1_rv); end
    // back-to-back: a refetch offered at T+3 must be taken immediately
    wb_valid = 1'b1; wb_refetch = 1'b1; wb_pc = 32'h1c000400;
    #1;
    n_tests++; if (d1_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall: got %b want 0", d1_stall); end
    tick();
    clear_wb();
    #1;
    n_tests++; if (d1_flush !== 1'b1 || d1_ec !== 1'b0 || d1_erc !== 1'b0) begin n_fail++; $display("FAIL b2b_flush: flush %b excp %b ertn %b want 1 0 0", d1_flush, d1_ec, d1_erc); end
    tick();
    n_tests++; if (d1_rv !== 1'b1 || d1_rpc !== 32'h1c000404) begin n_fail++; $display("FAIL b2b_redirect: valid %b pc %h want 1 1c000404", d1_rv, d1_rpc); end
    settle(6);
  endtask

  task automatic test_tlbr_busy();
    int stalls = 0;
    int flushes = 0;
    wb_valid = 1'b1; wb_excp = 1'b1; wb_tlbrefill = 1'b1; wb_pc = 32'h1c000500;
    csr_eentry = 32'h1c008000; csr_tlbrentry = 32'h1c00e000; icache_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      stalls += int'(d1_stall);
      flushes += int'(d1_flush);
      tick();
    end
    n_tests++; if (stalls != 5 || flushes != 0) begin n_fail++; $display("FAIL tlbr_busy: stall cycles %0d flush cycles %0d want 5 0", stalls, flushes); end
    icache_busy = 1'b0; csr_tlbrentry = 32'h1c00f000;
    #1;
    n_tests++; if (d1_flush !== 1'b0) begin n_fail++; $display("FAIL tlbr_accept_cycle: flush %b want 0", d1_flush); end
    tick();
    clear_wb(); csr_tlbrentry = 32'h22222220;
    #1;
    n_tests++; if (d1_flush !== 1'b1 || d1_ec !== 1'b1 || d1_cpc !== 32'h1c000500) begin n_fail++; $display("FAIL tlbr_flush: flush %b excp %b pc %h want 1 1 1c000500", d1_flush, d1_ec, d1_cpc); end
    tick();
    n_tests++; if (d1_rv !== 1'b1 || d1_rpc !== 32'h1c00f000) begin n_fail++; $display("FAIL tlbr_redirect: valid %b pc %h want 1 1c00f000", d1_rv, d1_rpc); end
    settle(6);
  endtask

  task automatic test_wait_drop();
    wb_valid = 1'b1; wb_refetch = 1'b1; wb_pc = 32'h1c000700; icache_busy = 1'b1;
    #1;
    n_tests++; if (d1_stall !== 1'b1) begin n_fail++; $display("FAIL drop_stall: got %b want 1", d1_stall); end
    tick();
    wb_valid = 1'b0;
    #1;
    n_tests++; if (d1_stall !== 1'b0) begin n_fail++; $display("FAIL drop_nostall: got %b want 0", d1_stall); end
    tick();
    icache_busy = 1'b0;
    #1;
    n_tests++; if (u_dut.state_q !== IDLE || d1_flush !== 1'b0) begin n_fail++; $display("FAIL drop_idle: state %0d flush %b want IDLE 0", u_dut.state_q, d1_flush); end
    tick();
    n_tests++; if (d1_flush !== 1'b0 || d1_rv !== 1'b0) begin n_fail++; $display("FAIL drop_quiet: flush %b valid %b want 0 0", d1_flush, d1_rv); end
    settle(4);
  endtask

  task automatic test_ertn_hold();
    int pulses = 0;
    int rv_cycles = 0;
    wb_valid = 1'b1; wb_ertn = 1'b1; wb_pc = 32'h1c000200; csr_era = 32'h1c000204;
    redirect_ready = 1'b0;
    #1;
    pulses += int'(d1_erc); rv_cycles += int'(d1_rv);
    tick();
    clear_wb();
    #1;
    n_tests++; if (d1_flush !== 1'b1 || d1_erc !== 1'b1 || d1_ec !== 1'b0 || d1_cpc !== 32'h1c000200) begin n_fail++; $display("FAIL ertn_flush: flush %b ertn %b excp %b pc %h want 1 1 0 1c000200", d1_flush, d1_erc, d1_ec, d1_cpc); end
    pulses += int'(d1_erc); rv_cycles += int'(d1_rv);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) csr_era = 32'h33333330;
      if (i == 3) redirect_ready = 1'b1;
      #1;
      n_tests++; if (d1_rv !== 1'b1 || d1_rpc !== 32'h1c000204) begin n_fail++; $display("FAIL ertn_hold%0d: valid %b pc %h want 1 1c000204", i, d1_rv, d1_rpc); end
      pulses += int'(d1_erc); rv_cycles += int'(d1_rv);
      tick();
    end
    pulses += int'(d1_erc); rv_cycles += int'(d1_rv);
    n_tests++; if (d1_rv !== 1'b0) begin n_fail++; $display("FAIL ertn_release: valid %b want 0", d1_rv); end
    n_tests++; if (pulses != 1 || rv_cycles != 4) begin n_fail++; $display("FAIL ertn_counts: pulses %0d valid cycles %0d want 1 4", pulses, rv_cycles); end
    settle(6);
  endtask

  task automatic test_refetch_wrap();
    wb_valid = 1'b1; wb_refetch = 1'b1; wb_pc = 32'hfffffffc;
    tick();
    clear_wb();
    #1;
    n_tests++; if (d1_flush !== 1'b1 || d1_ec !== 1'b0 || d1_erc !== 1'b0) begin n_fail++; $display("FAIL wrap_flush: flush %b excp %b ertn %b want 1 0 0", d1_flush, d1_ec, d1_erc); end
    tick();
    n_tests++; if (d1_rv !== 1'b1 || d1_rpc !== 32'h00000000) begin n_fail++; $display("FAIL wrap_redirect: valid %b pc %h want 1 00000000", d1_rv, d1_rpc); end
    settle(6);
  endtask

  task automatic test_flush3();
    logic ef, ee, ev;
    wb_valid = 1'b1; wb_excp = 1'b1; wb_ertn = 1'b1; wb_pc = 32'h1c000300;
    csr_eentry = 32'h1c008000; csr_era = 32'h1c000204;
    tick();
    clear_wb();
    for (int i = 1; i <= 5; i++) begin
      ef = (i <= 3);
      ee = (i == 1);
      ev = (i == 4);
      #1;
      n_tests++; if (d3_flush !== ef || d3_ec !== ee || d3_erc !== 1'b0 || d3_rv !== ev) begin n_fail++; $display("FAIL flush3_c%0d: flush %b excp %b ertn %b valid %b want %b %b 0 %b", i, d3_flush, d3_ec, d3_erc, d3_rv, ef, ee, ev); end
      if (i == 1) begin
        n_tests++; if (d1_ec !== 1'b1 || d1_erc !== 1'b0 || d3_cpc !== 32'h1c000300) begin n_fail++; $display("FAIL both_prio: excp %b ertn %b pc %h want 1 0 1c000300", d1_ec, d1_erc, d3_cpc); end
      end
      if (i == 4) begin
        n_tests++; if (d3_rpc !== 32'h1c008000) begin n_fail++; $display("FAIL flush3_target: got %h want 1c008000", d3_rpc); end
      end
      tick();
    end
    settle(4);
  endtask

  task automatic test_reset_mid();
    wb_valid = 1'b1; wb_refetch = 1'b1; wb_pc = 32'h1c000600; redirect_ready = 1'b0;
    tick();
    clear_wb();
    tick();
    n_tests++; if (d1_rv !== 1'b1 || d1_rpc !== 32'h1c000604) begin n_fail++; $display("FAIL mid_redirect: valid %b pc %h want 1 1c000604", d1_rv, d1_rpc); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    n_tests++; if ({d1_stall, d1_flush, d1_ec, d1_erc, d1_rv, d3_flush, d3_rv} !== 7'b0 || d1_rpc !== 32'h0) begin n_fail++; $display("FAIL mid_reset_outs: flags %b pc %h want 0", {d1_stall, d1_flush, d1_ec, d1_erc, d1_rv, d3_flush, d3_rv}, d1_rpc); end
    n_tests++; if (u_dut.state_q !== IDLE) begin n_fail++; $display("FAIL mid_reset_state: got %0d want IDLE", u_dut.state_q); end
    wb_valid = 1'b1; wb_refetch = 1'b1; wb_pc = 32'h1c000700;
    tick();
    clear_wb();
    #1;
    n_tests++; if (d1_flush !== 1'b1) begin n_fail++; $display("FAIL post_reset_flush: got %b want 1", d1_flush); end
    tick();
    n_tests++; if (d1_rv !== 1'b1 || d1_rpc !== 32'h1c000704) begin n_fail++; $display("FAIL post_reset_redirect: valid %b pc %h want 1 1c000704", d1_rv, d1_rpc); end
    redirect_ready = 1'b1;
    tick();
    n_tests++; if (d1_rv !== 1'b0) begin n_fail++; $display("FAIL post_reset_done: valid %b want 0", d1_rv); end
    settle(6);
  endtask

  initial begin
    test_reset();
    test_excp_basic();
    test_tlbr_busy();
    test_wait_drop();
    test_ertn_hold();
    test_refetch_wrap();
    test_flush3();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
